// File: rtl/bridge_pkg.sv
// Shared constants and types for the byte-to-block bridge and its transmit-side serializer.
// Both sides must agree on byte width, block size and byte order.
package bridge_pkg;

    localparam int BYTE_W    = 8;
    localparam int NUM_BYTES = 66;
    localparam int DATA_W    = BYTE_W * NUM_BYTES;
    localparam int CNT_W     = 7;

    typedef logic [DATA_W-1:0] block_t;
    typedef logic [BYTE_W-1:0] byte_t;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } ser_state_t;

    // Index of the final byte; counting stops here rather than wrapping.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES - 1);

endpackage

// File: rtl/block_serializer.sv
// Captures one 528-bit block and emits it MSB-first as 66 bytes under valid/ready.
// All outputs decode registered state only, so load/byte_ready never reach an output combinationally.
module block_serializer
    import bridge_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  block_t data_in,
    output logic   load_ready,
    output byte_t  byte_out,
    output logic   byte_valid,
    input  logic   byte_ready,
    output logic   done
);

    ser_state_t       state;
    ser_state_t       state_nxt;
    block_t           shreg;
    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The head byte always sits in the top BYTE_W bits; accepted bytes shift out with zero fill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        shreg <= data_in;
                        count <= '0;
                    end
                end
                SEND: begin
                    if (byte_ready && (count != LAST_CNT)) begin
                        shreg <= shreg << BYTE_W;
                        count <= count + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (load) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (byte_ready && (count == LAST_CNT)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        load_ready = 1'b0;
        byte_valid = 1'b0;
        byte_out   = '0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                load_ready = 1'b1;
            end
            SEND: begin
                byte_valid = 1'b1;
                byte_out   = shreg[DATA_W-1 -: BYTE_W];
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_block_serializer.sv
// Self-checking bench for block_serializer: a queue-based model of the byte stream plus a
// bench-side bridge that rebuilds each block from the accepted bytes.
module tb_block_serializer;
    import bridge_pkg::*;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    logic   load = 1'b0;
    logic   byte_ready = 1'b0;
    block_t data_in = '0;
    logic   load_ready;
    byte_t  byte_out;
    logic   byte_valid;
    logic   done;

    block_serializer dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .data_in    (data_in),
        .load_ready (load_ready),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: a block becomes a queue of pending bytes; one done cycle follows the last.
    byte_t  m_q[$];
    bit     m_done = 1'b0;
    block_t m_blk = '0;
    int     cyc = 0;
    int     cap_cyc[$];
    int     done_seen = 0;
    block_t bridge = '0;
    byte_t  acc[$];
    logic   s_valid = 1'b0;
    byte_t  s_out = '0;

    function automatic void model_reset();
        m_q.delete();
        m_done = 1'b0;
    endfunction

    always @(negedge clk) begin
        logic  exp_valid;
        byte_t exp_out;
        if (rst) model_reset();
        exp_valid = (m_q.size() > 0);
        exp_out   = exp_valid ? m_q[0] : '0;
        check("byte_valid", byte_valid, exp_valid);
        check("byte_out", byte_out, exp_out);
        check("load_ready", load_ready, !exp_valid && !m_done);
        check("done", done, m_done);
        if (done === 1'b1) begin
            done_seen++;
            check("loopback", bridge, m_blk);
        end
        s_valid = byte_valid;
        s_out   = byte_out;
    end

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            model_reset();
        end else begin
            if (s_valid && byte_ready) begin
                bridge = {bridge[DATA_W-BYTE_W-1:0], s_out};
                acc.push_back(s_out);
            end
            if (m_done) begin
                m_done = 1'b0;
            end else if (m_q.size() > 0) begin
                if (byte_ready) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) m_done = 1'b1;
                end
            end else if (load) begin
                m_blk = data_in;
                for (int k = 0; k < NUM_BYTES; k++) m_q.push_back(data_in[DATA_W-1-BYTE_W*k -: BYTE_W]);
                cap_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic block_t rand_block();
        block_t b;
        for (int i = 0; i < NUM_BYTES; i++) b[BYTE_W*i +: BYTE_W] = byte_t'($urandom);
        return b;
    endfunction

    // Loads one block and drains it; took is the 1-based cycle in which done appeared, -1 on timeout.
    task automatic run_block(input block_t blk, input bit rnd_ready, output int took);
        data_in    = blk;
        load       = 1'b1;
        byte_ready = 1'b1;
        tick();
        load = 1'b0;
        took = -1;
        for (int c = 1; c <= 400; c++) begin
            if (done) begin
                took = c;
                break;
            end
            byte_ready = rnd_ready ? (($urandom % 4) != 0) : 1'b1;
            tick();
        end
        check("done_timeout", took > 0, 1'b1);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int     took;
        int     dcyc;
        int     ndone;
        int     sends;
        int     n0;
        int     d0;
        logic   prev_ready;
        byte_t  prev_out;
        block_t blk;
        block_t blk_a;
        block_t blk_b;

        // Reset state.
        rst = 1'b1;
        tick();
        check("rst_load_ready", load_ready, 1'b1);
        check("rst_byte_valid", byte_valid, 1'b0);
        check("rst_byte_out", byte_out, 8'h00);
        check("rst_done", done, 1'b0);
        tick();
        rst = 1'b0;
        tick();

        // Single marked byte at the top; done appears in cycle 67 counting the cycle after load as 1.
        data_in    = {8'h81, 520'h0};
        byte_ready = 1'b1;
        load       = 1'b1;
        tick();
        load = 1'b0;
        check("t1_first", byte_out, 8'h81);
        dcyc  = -1;
        ndone = 0;
        for (int c = 1; c <= 80; c++) begin
            if (c == 2) check("t1_second", byte_out, 8'h00);
            if (done) begin
                ndone++;
                if (dcyc < 0) dcyc = c;
            end
            tick();
        end
        check("t1_done_cycle", dcyc, 67);
        check("t1_done_once", ndone, 1);

        // Ascending bytes with byte_ready toggling 1/0.
        for (int k = 0; k < NUM_BYTES; k++) data_in[DATA_W-1-BYTE_W*k -: BYTE_W] = byte_t'(k);
        acc.delete();
        byte_ready = 1'b1;
        load       = 1'b1;
        tick();
        load       = 1'b0;
        sends      = 0;
        prev_ready = 1'b1;
        prev_out   = '0;
        took       = -1;
        for (int c = 1; c <= 300; c++) begin
            if (done) begin
                took = c;
                break;
            end
            byte_ready = (c % 2) == 1;
            if (byte_valid) sends++;
            if (!prev_ready && byte_valid) check("t2_stable", byte_out, prev_out);
            prev_out   = byte_out;
            prev_ready = byte_ready;
            tick();
        end
        check("t2_done_seen", took > 0, 1'b1);
        check("t2_send_cycles", sends, 131);
        check("t2_count", acc.size(), NUM_BYTES);
        for (int k = 0; k < acc.size(); k++) check("t2_seq", acc[k], k);
        byte_ready = 1'b1;
        tick();

        // Loopback through the bench bridge with fixed and random patterns.
        run_block('0, 1'b1, took);
        check("t3_zero", bridge, '0);
        run_block('1, 1'b1, took);
        check("t3_ones", bridge, '1);
        blk = {520'h0, 8'h81};
        run_block(blk, 1'b1, took);
        check("t3_low81", bridge, blk);
        for (int i = 0; i < 3; i++) begin
            blk = rand_block();
            run_block(blk, 1'b1, took);
            check("t3_rand", bridge, blk);
        end

        // Load during SEND is ignored.
        blk_a      = rand_block();
        blk_b      = rand_block();
        data_in    = blk_a;
        byte_ready = 1'b1;
        load       = 1'b1;
        tick();
        load = 1'b0;
        repeat (10) tick();
        check("t4_at_byte10", byte_out, blk_a[DATA_W-1-BYTE_W*10 -: BYTE_W]);
        data_in = blk_b;
        load    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("t4_load_ready", load_ready, 1'b0);
            tick();
        end
        load = 1'b0;
        took = -1;
        for (int c = 1; c <= 100; c++) begin
            if (done) begin
                took = c;
                break;
            end
            check("t4_load_ready", load_ready, 1'b0);
            tick();
        end
        check("t4_done_seen", took > 0, 1'b1);
        check("t4_orig", bridge, blk_a);
        tick();
        check("t4_idle", load_ready, 1'b1);

        // Reset in the middle of a block.
        blk_a      = rand_block();
        data_in    = blk_a;
        byte_ready = 1'b1;
        load       = 1'b1;
        tick();
        load = 1'b0;
        repeat (30) tick();
        check("t5_byte30", byte_out, blk_a[DATA_W-1-BYTE_W*30 -: BYTE_W]);
        rst = 1'b1;
        #1;
        check("t5_async_valid", byte_valid, 1'b0);
        check("t5_async_ready", load_ready, 1'b1);
        check("t5_async_out", byte_out, 8'h00);
        tick();
        rst = 1'b0;
        d0  = done_seen;
        repeat (5) tick();
        check("t5_no_done", done_seen, d0);
        blk = rand_block();
        run_block(blk, 1'b0, took);
        check("t5_fresh", bridge, blk);

        // Back-to-back loads with load held high.
        acc.delete();
        n0         = cap_cyc.size();
        d0         = done_seen;
        byte_ready = 1'b1;
        load       = 1'b1;
        for (int i = 0; i < 206; i++) begin
            data_in = rand_block();
            tick();
        end
        load = 1'b0;
        check("t6_captures", cap_cyc.size() - n0, 4);
        check("t6_dones", done_seen - d0, 3);
        for (int i = n0 + 1; i < cap_cyc.size(); i++) check("t6_interval", cap_cyc[i] - cap_cyc[i-1], 68);
        took = -1;
        for (int c = 1; c <= 100; c++) begin
            if (done) begin
                took = c;
                break;
            end
            tick();
        end
        check("t6_last_done", took > 0, 1'b1);
        tick();
        check("t6_bytes", acc.size(), 4 * NUM_BYTES);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
